pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
//
// PURPOSE
// - Parametrised program counter with an integrated hardware return-address stack.
// - Supports reset, load, increment with programmable wrap, subroutine call and subroutine return.
// - Sits between the control FSM and the instruction-memory address bus; drives the fetch address.
// - Call/return is handled entirely in hardware, so the control unit needs no RAM stack-pointer path.
//
// PARAMETERS
// - W         10  PC width in bits (legal 4..32)
// - RESET_VEC 1   PC value after reset
// - WRAP_VEC  1   PC value after incrementing from all-ones (2**W-1)
// - DEPTH     8   return-stack entries (legal 1..64)
// - DW        $clog2(DEPTH+1)  width of STK_CNT (derived; not to be overridden)
//
// PORTS
// - CLK        in   1   clock; all state updates on rising edge
// - RST        in   1   async active-high reset
// - DIN        in   W   load / call target address
// - PC_LD      in   1   load PC from DIN
// - PC_INC     in   1   advance PC by one (with wrap)
// - PC_CALL    in   1   push return address, PC <= DIN
// - PC_RET     in   1   PC <= popped return address
// - ERR_CLR    in   1   synchronous clear of STK_ERR
// - PC_COUNT   out  W   current program counter (registered)
// - STK_CNT    out  DW  number of valid stack entries (registered)
// - STK_FULL   out  1   STK_CNT == DEPTH (combinational from STK_CNT)
// - STK_EMPTY  out  1   STK_CNT == 0 (combinational from STK_CNT)
// - STK_ERR    out  1   sticky: overflow or underflow has occurred
//
// BEHAVIOUR
// - Reset (RST=1, takes effect immediately, independent of CLK):
//   - PC_COUNT = RESET_VEC, STK_CNT = 0, STK_ERR = 0.
//   - Stack RAM contents are don't-care.
//   - Reset mid-operation discards any pending or in-flight op.
// - Command priority per edge, highest first: PC_RET > PC_CALL > PC_LD > PC_INC.
//   - Exactly one command executes per cycle; lower-priority commands asserted with it are ignored.
//   - No command asserted: all state holds.
// - nxt(PC) = (PC == 2**W-1) ? WRAP_VEC : PC+1. Unsigned arithmetic, no carry out.
// - INC: PC_COUNT <= nxt(PC_COUNT).
// - LD: PC_COUNT <= DIN.
// - CALL, stack not full:
//   - stack[STK_CNT] <= nxt(PC_COUNT); STK_CNT++; PC_COUNT <= DIN.
//   - New values are visible the cycle after the edge.
// - CALL, stack full (overflow):
//   - PC_COUNT <= DIN, push discarded, STK_CNT unchanged, STK_ERR <= 1.
// - RET, stack not empty:
//   - PC_COUNT <= stack[STK_CNT-1]; STK_CNT--.
//   - One-edge latency: the returned address appears on PC_COUNT after the same edge.
//   - The stack read path must therefore be combinational (registers or async-read LUTRAM).
// - RET, stack empty (underflow):
//   - PC_COUNT holds, STK_CNT stays 0, STK_ERR <= 1.
// - Back-to-back CALL then RET on consecutive cycles returns the address pushed one cycle earlier.
//   - No bubble; the entry is written and read through registered state.
// - STK_ERR clears only via RST or ERR_CLR.
//   - If ERR_CLR and a new error occur on the same edge, the error wins (STK_ERR = 1).
// - All outputs are registered or decode registered state only; no combinational path from command inputs to outputs.
//
// TESTING
// - Reset default: assert RST asynchronously between edges.
//   -> PC_COUNT = 1 before the next edge, STK_CNT = 0, STK_EMPTY = 1.
// - Increment and wrap: PC_LD with DIN = 10'h3FE, then PC_INC x2.
//   -> PC_COUNT 3FE, 3FF, 001.
//   - Repeat with WRAP_VEC = 0 -> 000.
// - Nested call/return: PC = 0x010, CALL DIN = 0x100; CALL DIN = 0x200; RET; RET.
//   -> PC 100, 200, 101, 011; STK_CNT 1, 2, 1, 0.
// - Priority: assert PC_RET, PC_CALL, PC_LD and PC_INC together with stack holding 0x055.
//   -> PC = 0x055, STK_CNT decrements, no push.
//   - With the stack empty -> PC holds, STK_ERR = 1.
// - Overflow: DEPTH = 8, issue 9 CALLs.
//   -> STK_FULL after the 8th; 9th sets STK_ERR, PC = DIN, STK_CNT = 8.
//   - 8 RETs then return the 8 pushed addresses in LIFO order.
// - Error clear and reset mid-op: ERR_CLR with no error -> STK_ERR = 0.
//   - ERR_CLR with an underflow RET on the same edge -> STK_ERR = 1.
//   - RST during a CALL cycle -> PC = RESET_VEC, STK_CNT = 0.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Command/status bundle between the control FSM and the program counter / return stack.
// master = controller side, slave = pc_stack_unit side.
interface pc_stack_unit_if #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic [W-1:0]  din;
    logic          pc_ld;
    logic          pc_inc;
    logic          pc_call;
    logic          pc_ret;
    logic          err_clr;
    logic [W-1:0]  pc_count;
    logic [DW-1:0] stk_cnt;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;

    modport master (
        output din, pc_ld, pc_inc, pc_call, pc_ret, err_clr,
        input  pc_count, stk_cnt, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  din, pc_ld, pc_inc, pc_call, pc_ret, err_clr,
        output pc_count, stk_cnt, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with programmable wrap and an integrated hardware return-address stack.
// One command per edge, priority RET > CALL > LD > INC; stack read is combinational.
module pc_stack_unit #(
    parameter int unsigned W         = 10,
    parameter int unsigned RESET_VEC = 1,
    parameter int unsigned WRAP_VEC  = 1,
    parameter int unsigned DEPTH     = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    pc_stack_unit_if.slave  bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (W < 4 || W > 32) begin : g_bad_w
        $error("pc_stack_unit: W out of range");
    end
    if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
        $error("pc_stack_unit: DEPTH out of range");
    end

    logic [W-1:0]  r_pc;
    logic [DW-1:0] r_cnt;
    logic          r_err;
    logic [W-1:0]  r_stack [DEPTH];

    logic [W-1:0]  w_pc_d;
    logic [DW-1:0] w_cnt_d;
    logic          w_err_d;
    logic [W-1:0]  w_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [DW-1:0] w_cnt_m1;

    assign w_full   = (r_cnt == DW'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_nxt    = (r_pc == {W{1'b1}}) ? WRAP_VEC[W-1:0] : r_pc + W'(1);
    assign w_cnt_m1 = r_cnt - DW'(1);
    assign w_wr_idx = r_cnt[AW-1:0];
    assign w_rd_idx = w_cnt_m1[AW-1:0];

    always_comb begin
        w_pc_d  = r_pc;
        w_cnt_d = r_cnt;
        w_err_d = r_err & ~bus.err_clr;
        w_push  = 1'b0;
        if (bus.pc_ret) begin
            if (w_empty) begin
                w_err_d = 1'b1;
            end else begin
                w_pc_d  = r_stack[w_rd_idx];
                w_cnt_d = w_cnt_m1;
            end
        end else if (bus.pc_call) begin
            w_pc_d = bus.din;
            if (w_full) begin
                w_err_d = 1'b1;
            end else begin
                w_push  = 1'b1;
                w_cnt_d = r_cnt + DW'(1);
            end
        end else if (bus.pc_ld) begin
            w_pc_d = bus.din;
        end else if (bus.pc_inc) begin
            w_pc_d = w_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc  <= RESET_VEC[W-1:0];
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_d;
            r_cnt <= w_cnt_d;
            r_err <= w_err_d;
        end
    end

    // Contents need no reset; the count alone defines which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_stack[w_wr_idx] <= w_nxt;
        end
    end

    assign bus.pc_count  = r_pc;
    assign bus.stk_cnt   = r_cnt;
    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.stk_err   = r_err;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed checks of pc_stack_unit against a queue-based behavioural model.
module tb_pc_stack_unit;
    localparam int unsigned W     = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned MAXPC = (1 << W) - 1;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [W-1:0] r_din = '0;
    logic r_ld = 0, r_inc = 0, r_call = 0, r_ret = 0, r_clr = 0;

    pc_stack_unit_if #(.W(W), .DEPTH(DEPTH)) bus ();
    pc_stack_unit_if #(.W(W), .DEPTH(DEPTH)) bus0 ();

    assign bus.din      = r_din;
    assign bus.pc_ld    = r_ld;
    assign bus.pc_inc   = r_inc;
    assign bus.pc_call  = r_call;
    assign bus.pc_ret   = r_ret;
    assign bus.err_clr  = r_clr;
    assign bus0.din     = r_din;
    assign bus0.pc_ld   = r_ld;
    assign bus0.pc_inc  = r_inc;
    assign bus0.pc_call = r_call;
    assign bus0.pc_ret  = r_ret;
    assign bus0.err_clr = r_clr;

    pc_stack_unit #(.W(W), .RESET_VEC(1), .WRAP_VEC(1), .DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    pc_stack_unit #(.W(W), .RESET_VEC(1), .WRAP_VEC(0), .DEPTH(DEPTH)) dut_wrap0 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus0)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_pc;
    int m_stk[$];
    bit m_err;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nxt(input int pc, input int wrap);
        return (pc == MAXPC) ? wrap : pc + 1;
    endfunction

    task automatic model_reset();
        m_pc  = 1;
        m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        bit new_err = 0;
        if (r_ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else new_err = 1;
        end else if (r_call) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(nxt(m_pc, 1));
            else new_err = 1;
            m_pc = int'(r_din);
        end else if (r_ld) begin
            m_pc = int'(r_din);
        end else if (r_inc) begin
            m_pc = nxt(m_pc, 1);
        end
        if (new_err) m_err = 1;
        else if (r_clr) m_err = 0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".pc"},    int'(bus.pc_count),  m_pc);
        check_val({tag, ".cnt"},   int'(bus.stk_cnt),   m_stk.size());
        check_val({tag, ".full"},  int'(bus.stk_full),  int'(m_stk.size() == DEPTH));
        check_val({tag, ".empty"}, int'(bus.stk_empty), int'(m_stk.size() == 0));
        check_val({tag, ".err"},   int'(bus.stk_err),   int'(m_err));
    endtask

    // Drive on the falling edge, let one rising edge act, sample 1 time unit later.
    task automatic step(input string tag, input bit rt, input bit cl, input bit ld,
                        input bit ic, input bit ec, input int d);
        @(negedge i_clk);
        r_ret = rt; r_call = cl; r_ld = ld; r_inc = ic; r_clr = ec;
        r_din = W'(d);
        model_step();
        @(posedge i_clk);
        #1;
        check_all(tag);
        r_ret = 0; r_call = 0; r_ld = 0; r_inc = 0; r_clr = 0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        model_reset();
        async_reset("reset");
        check_val("reset.pc_const", int'(bus.pc_count), 1);

        // Increment and wrap for both wrap vectors.
        step("wrap.ld", 0, 0, 1, 0, 0, 'h3FE);
        step("wrap.inc1", 0, 0, 0, 1, 0, 0);
        check_val("wrap.3ff", int'(bus.pc_count), 'h3FF);
        step("wrap.inc2", 0, 0, 0, 1, 0, 0);
        check_val("wrap.to1", int'(bus.pc_count), 'h001);
        check_val("wrap.to0", int'(bus0.pc_count), 'h000);

        // Nested call / return.
        step("nest.ld", 0, 0, 1, 0, 0, 'h010);
        step("nest.call1", 0, 1, 0, 0, 0, 'h100);
        step("nest.call2", 0, 1, 0, 0, 0, 'h200);
        step("nest.ret1", 1, 0, 0, 0, 0, 0);
        check_val("nest.ret1_const", int'(bus.pc_count), 'h101);
        step("nest.ret2", 1, 0, 0, 0, 0, 0);
        check_val("nest.ret2_const", int'(bus.pc_count), 'h011);

        // Priority: RET wins over everything, then underflow with all asserted.
        step("prio.ld", 0, 0, 1, 0, 0, 'h054);
        step("prio.call", 0, 1, 0, 0, 0, 'h200);
        step("prio.all", 1, 1, 1, 1, 0, 'h300);
        check_val("prio.pc_const", int'(bus.pc_count), 'h055);
        step("prio.all_empty", 1, 1, 1, 1, 0, 'h300);
        check_val("prio.err_const", int'(bus.stk_err), 1);

        // Error clear behaviour.
        step("clr.plain", 0, 0, 0, 0, 1, 0);
        step("clr.noerr", 0, 0, 0, 0, 1, 0);
        step("clr.vs_underflow", 1, 0, 0, 0, 1, 0);
        check_val("clr.err_wins", int'(bus.stk_err), 1);
        step("clr.again", 0, 0, 0, 0, 1, 0);

        // Overflow then LIFO drain.
        step("ovf.ld", 0, 0, 1, 0, 0, 'h020);
        for (int k = 0; k < 9; k++) begin
            step($sformatf("ovf.call%0d", k), 0, 1, 0, 0, 0, 'h040 + k * 'h10);
        end
        check_val("ovf.cnt_const", int'(bus.stk_cnt), DEPTH);
        check_val("ovf.pc_const", int'(bus.pc_count), 'h0C0);
        for (int k = 0; k < 8; k++) begin
            step($sformatf("ovf.ret%0d", k), 1, 0, 0, 0, 0, 0);
        end
        check_val("ovf.last_ret", int'(bus.pc_count), 'h021);

        // Reset landing on a CALL edge discards the call.
        step("rstcall.pre", 0, 1, 0, 0, 0, 'h0AA);
        @(negedge i_clk);
        r_call = 1; r_din = 'h155; i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        model_reset();
        check_all("rstcall");
        @(negedge i_clk);
        i_rst = 1'b0; r_call = 0;

        // Randomised mix with the model tracking everything.
        for (int n = 0; n < 1500; n++) begin
            int d;
            int sel;
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand.reset");
            end else begin
                sel = $urandom_range(0, 9);
                d = (sel < 2) ? ('h3FE + sel) : int'($urandom_range(0, MAXPC));
                step("rand",
                     $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 10, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
